// File: rtl/cla4_serial_ctrl_if.sv
// rtl/cla4_serial_ctrl_if.sv - request/result handshake bundle for cla4_serial_ctrl
//
// Purpose: groups the producer-side request (in_valid/in_ready, a, b, cin, sub)
// and consumer-side result (out_valid/out_ready, y, cout, ovf) of the serial
// adder into one bundle.
// Modports:
//   master - producer/consumer side: drives the request and out_ready
//   slave  - the adder: drives in_ready and the result
interface cla4_serial_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, y, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, y, cout, ovf
   );
endinterface

// File: rtl/cla4_serial_ctrl.sv
// rtl/cla4_serial_ctrl.sv - nibble-serial add/subtract sequencer around one cla4 slice
//
// Purpose: adds (a+b+cin) or subtracts (a-b) WIDTH-bit operands four bits per
// clock, least significant nibble first, through a single 4-bit carry
// look-ahead slice. A registered carry links consecutive nibbles.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - cla4_serial_ctrl_if.slave:
//              in_valid/in_ready, a, b, cin, sub   request (sampled on accept)
//              out_valid/out_ready, y, cout, ovf   result (held while out_valid)

module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:1] c;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is formed directly from generate/propagate terms and cin.
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s    = p ^ {c[3:1], cin};
   assign cout = c[4];
endmodule

module cla4_serial_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   cla4_serial_ctrl_if.slave  bus
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
         $error("cla4_serial_ctrl: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_n;

   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;      // already inverted for subtraction
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             cout_r;
   logic             ovf_r;

   logic [CW+1:0]    base;
   logic [3:0]       nib_sum;
   logic             nib_cout;
   logic             last;

   assign base = {cnt, 2'b00};
   assign last = (cnt == CW'(NIB - 1));

   cla4 u_cla4 (
      .a    (a_r[base +: 4]),
      .b    (b_r[base +: 4]),
      .cin  (carry),
      .s    (nib_sum),
      .cout (nib_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n       = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_n = RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_n = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r    <= '0;
         b_r    <= '0;
         res    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_r   <= bus.a;
                  // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry.
                  b_r   <= bus.sub ? ~bus.b : bus.b;
                  carry <= bus.sub ? 1'b1 : bus.cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               res[base +: 4] <= nib_sum;
               carry          <= nib_cout;
               if (last) begin
                  cnt    <= '0;
                  cout_r <= nib_cout;
                  // Signed overflow: like-signed operands giving an unlike-signed sum.
                  ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (nib_sum[3] != a_r[WIDTH-1]);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.y    = res;
   assign bus.cout = cout_r;
   assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_cla4_serial_ctrl.sv
// tb/tb_cla4_serial_ctrl.sv - self-checking bench for cla4_serial_ctrl at WIDTH 4, 8 and 16
module tb_cla4_serial_ctrl;
   logic clk;
   logic rst_n;

   int checks;
   int failures;

   cla4_serial_ctrl_if #(.WIDTH(4))  i4 ();
   cla4_serial_ctrl_if #(.WIDTH(8))  i8 ();
   cla4_serial_ctrl_if #(.WIDTH(16)) i16 ();

   cla4_serial_ctrl #(.WIDTH(4))  d4  (.clk(clk), .rst_n(rst_n), .bus(i4));
   cla4_serial_ctrl #(.WIDTH(8))  d8  (.clk(clk), .rst_n(rst_n), .bus(i8));
   cla4_serial_ctrl #(.WIDTH(16)) d16 (.clk(clk), .rst_n(rst_n), .bus(i16));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] y;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input int w, input logic v, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb, input logic ordy);
      case (w)
         4: begin
            i4.in_valid = v; i4.a = av[3:0]; i4.b = bv[3:0];
            i4.cin = ci; i4.sub = sb; i4.out_ready = ordy;
         end
         8: begin
            i8.in_valid = v; i8.a = av[7:0]; i8.b = bv[7:0];
            i8.cin = ci; i8.sub = sb; i8.out_ready = ordy;
         end
         default: begin
            i16.in_valid = v; i16.a = av; i16.b = bv;
            i16.cin = ci; i16.sub = sb; i16.out_ready = ordy;
         end
      endcase
   endtask

   function automatic logic get_ov(input int w);
      case (w)
         4:       return i4.out_valid;
         8:       return i8.out_valid;
         default: return i16.out_valid;
      endcase
   endfunction

   function automatic logic get_ir(input int w);
      case (w)
         4:       return i4.in_ready;
         8:       return i8.in_ready;
         default: return i16.in_ready;
      endcase
   endfunction

   function automatic logic [15:0] get_y(input int w);
      case (w)
         4:       return {12'd0, i4.y};
         8:       return {8'd0, i8.y};
         default: return i16.y;
      endcase
   endfunction

   function automatic logic [1:0] get_cf(input int w);
      case (w)
         4:       return {i4.cout, i4.ovf};
         8:       return {i8.cout, i8.ovf};
         default: return {i16.cout, i16.ovf};
      endcase
   endfunction

   // Reference: whole-word integer arithmetic, signed range check for overflow.
   function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic ci, input logic sb,
                                 output logic [15:0] ye, output logic ce, output logic oe);
      longint md, ua, ub, sa, sbv, r, sr;
      md  = longint'(1) << w;
      ua  = longint'(av) & (md - 1);
      ub  = longint'(bv) & (md - 1);
      sa  = (ua >= md / 2) ? ua - md : ua;
      sbv = (ub >= md / 2) ? ub - md : ub;
      if (sb) begin
         r  = ua - ub;
         ce = (ua >= ub);
         sr = sa - sbv;
      end else begin
         r  = ua + ub + longint'(ci);
         ce = (r >= md);
         sr = sa + sbv + longint'(ci);
      end
      ye = 16'(r & (md - 1));
      oe = (sr >= md / 2) || (sr < -(md / 2));
   endfunction

   // One full transaction; a/b/cin/sub are scrambled right after accept.
   task automatic do_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb,
                        output logic [15:0] yv, output logic co, output logic ov,
                        output int lat, output logic rdy_idle, output logic rdy_run);
      @(negedge clk);
      rdy_idle = get_ir(w);
      drive(w, 1'b1, av, bv, ci, sb, 1'b0);
      @(negedge clk);
      drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      rdy_run = get_ir(w);
      lat = 0;
      while (!get_ov(w) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      yv = get_y(w);
      {co, ov} = get_cf(w);
      drive(w, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      drive(w, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [15:0] yv, ye, av, bv;
      logic        co, ov, ce, oe, ci, sb, ri, rr;
      int          lat;

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      drive(4, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      drive(8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      drive(16, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);

      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      vecs[5] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};

      #12;
      chk("reset_y", i16.y, 16'h0000);
      chk("reset_cout", i16.cout, 1'b0);
      chk("reset_ovf", i16.ovf, 1'b0);
      chk("reset_out_valid", i16.out_valid, 1'b0);
      chk("reset_in_ready", i16.in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors at WIDTH=16
      foreach (vecs[k]) begin
         do_op(16, vecs[k].a, vecs[k].b, vecs[k].cin, vecs[k].sub, yv, co, ov, lat, ri, rr);
         chk($sformatf("vec%0d_y", k), yv, vecs[k].y);
         chk($sformatf("vec%0d_cout", k), co, vecs[k].cout);
         chk($sformatf("vec%0d_ovf", k), ov, vecs[k].ovf);
         chk($sformatf("vec%0d_latency", k), lat, 4);
         chk($sformatf("vec%0d_in_ready_idle", k), ri, 1'b1);
         chk($sformatf("vec%0d_in_ready_run", k), rr, 1'b0);
         chk($sformatf("vec%0d_out_valid_after", k), i16.out_valid, 1'b0);
         chk($sformatf("vec%0d_in_ready_after", k), i16.in_ready, 1'b1);
      end

      // Backpressure in DONE: result held, request ignored
      @(negedge clk);
      drive(16, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
      lat = 0;
      @(negedge clk);
      while (!i16.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("hold_latency", lat, 4);
      for (int k = 0; k < 3; k++) begin
         drive(16, 1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b0);
         @(negedge clk);
         chk($sformatf("hold%0d_y", k), i16.y, 16'h3333);
         chk($sformatf("hold%0d_cout", k), i16.cout, 1'b0);
         chk($sformatf("hold%0d_ovf", k), i16.ovf, 1'b0);
         chk($sformatf("hold%0d_out_valid", k), i16.out_valid, 1'b1);
         chk($sformatf("hold%0d_in_ready", k), i16.in_ready, 1'b0);
      end
      drive(16, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("release_out_valid", i16.out_valid, 1'b0);
      chk("release_in_ready", i16.in_ready, 1'b1);
      drive(16, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of RUN after two nibbles
      @(negedge clk);
      drive(16, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(16, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_y", i16.y, 16'h0000);
      chk("midrun_reset_cout", i16.cout, 1'b0);
      chk("midrun_reset_ovf", i16.ovf, 1'b0);
      chk("midrun_reset_out_valid", i16.out_valid, 1'b0);
      chk("midrun_reset_in_ready", i16.in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(16, 16'hA5A5, 16'h5A5B, 1'b0, 1'b0, yv, co, ov, lat, ri, rr);
      chk("post_reset_y", yv, 16'h0000);
      chk("post_reset_cout", co, 1'b1);
      chk("post_reset_ovf", ov, 1'b0);
      chk("post_reset_latency", lat, 4);

      // Random operations against the reference model
      for (int k = 0; k < 1000; k++) begin
         for (int s = 0; s < 3; s++) begin
            int w;
            w = (s == 0) ? 4 : (s == 1) ? 8 : 16;
            if (w == 16 && k >= 200) continue;
            av = 16'($urandom);
            bv = 16'($urandom);
            ci = 1'($urandom);
            sb = 1'($urandom);
            model(w, av, bv, ci, sb, ye, ce, oe);
            do_op(w, av, bv, ci, sb, yv, co, ov, lat, ri, rr);
            chk($sformatf("rnd_w%0d_%0d_y a=%h b=%h cin=%b sub=%b", w, k, av, bv, ci, sb), yv, ye);
            chk($sformatf("rnd_w%0d_%0d_cout", w, k), co, ce);
            chk($sformatf("rnd_w%0d_%0d_ovf", w, k), ov, oe);
            chk($sformatf("rnd_w%0d_%0d_latency", w, k), lat, w / 4);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
